rf_write_scheduler: RTL

Write-back scheduler for the 16 x 16-bit register file in the 5-stage pipelined datapath. It accepts register write requests from two producers: A, the pipeline write-back stage, and B, the multi-cycle unit such as multiply/divide, which may write two registers. It arbitrates between them round-robin and buffers accepted requests in a small FIFO. It drains one request per cycle onto the register file's write controls (RegWrite, WriteOP2, WriteReg1/2, WriteData1/2), and exposes a per-register pending scoreboard that decode uses for stall decisions.

---
 rtl/rf_wsched_pkg.sv | 47 ++++
 rtl/rf_write_scheduler_if.sv | 42 ++++
 rtl/rf_wsched_fifo.sv | 91 +++++++++
 rtl/rf_write_scheduler.sv | 134 +++++++++++++
 4 files changed

// File: rtl/rf_wsched_pkg.sv
// rf_wsched_pkg: shared types and constants for the register-file write scheduler.
//   - RF_DATA_W / RF_ADDR_W / RF_DEPTH : default widths and FIFO depth
//   - req_e       : requester encoding (REQ_A = 0, REQ_B = 1)
//   - rf_entry_t  : one queued write request (dual, reg1, reg2, data1, data2)
//   - rf_normalize: folds a dual write with reg1 == reg2 into a single write
package rf_wsched_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 4;
    localparam int RF_DEPTH  = 4;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

    typedef struct packed {
        logic                 dual;
        logic [RF_ADDR_W-1:0] reg1;
        logic [RF_ADDR_W-1:0] reg2;
        logic [RF_DATA_W-1:0] data1;
        logic [RF_DATA_W-1:0] data2;
    } rf_entry_t;

    // Port 2 wins in the register file, so a dual write to one index is
    // just a single write of data2. Guarantees reg1 != reg2 for dual entries.
    function automatic rf_entry_t rf_normalize(
        input logic                 dual,
        input logic [RF_ADDR_W-1:0] r1,
        input logic [RF_ADDR_W-1:0] r2,
        input logic [RF_DATA_W-1:0] d1,
        input logic [RF_DATA_W-1:0] d2
    );
        rf_entry_t e;
        e.dual  = dual;
        e.reg1  = r1;
        e.reg2  = r2;
        e.data1 = d1;
        e.data2 = d2;
        if (dual && (r1 == r2)) begin
            e.dual  = 1'b0;
            e.data1 = d2;
        end
        return e;
    endfunction

endpackage

// File: rtl/rf_write_scheduler_if.sv
// rf_write_scheduler_if: request, register-file write and scoreboard query bus.
//   master : producers A/B, rf_hold, query indices (driven by the environment)
//   slave  : rf_write_scheduler side (ready, rf write controls, busy/forward, count)
interface rf_write_scheduler_if
    import rf_wsched_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              a_valid, a_ready, a_dual;
    logic [ADDR_W-1:0] a_reg1, a_reg2;
    logic [DATA_W-1:0] a_data1, a_data2;
    logic              b_valid, b_ready, b_dual;
    logic [ADDR_W-1:0] b_reg1, b_reg2;
    logic [DATA_W-1:0] b_data1, b_data2;
    logic              rf_hold, rf_we, rf_we2;
    logic [ADDR_W-1:0] rf_wreg1, rf_wreg2;
    logic [DATA_W-1:0] rf_wdata1, rf_wdata2;
    logic [ADDR_W-1:0] q_reg1, q_reg2;
    logic              q_busy1, q_busy2, q_fwd_valid1, q_fwd_valid2;
    logic [DATA_W-1:0] q_fwd_data1, q_fwd_data2;
    logic [CNT_W-1:0]  count;

    modport master (
        output a_valid, a_dual, a_reg1, a_reg2, a_data1, a_data2,
        output b_valid, b_dual, b_reg1, b_reg2, b_data1, b_data2,
        output rf_hold, q_reg1, q_reg2,
        input  a_ready, b_ready, rf_we, rf_we2, rf_wreg1, rf_wreg2, rf_wdata1, rf_wdata2,
        input  q_busy1, q_busy2, q_fwd_valid1, q_fwd_valid2, q_fwd_data1, q_fwd_data2, count
    );

    modport slave (
        input  a_valid, a_dual, a_reg1, a_reg2, a_data1, a_data2,
        input  b_valid, b_dual, b_reg1, b_reg2, b_data1, b_data2,
        input  rf_hold, q_reg1, q_reg2,
        output a_ready, b_ready, rf_we, rf_we2, rf_wreg1, rf_wreg2, rf_wdata1, rf_wdata2,
        output q_busy1, q_busy2, q_fwd_valid1, q_fwd_valid2, q_fwd_data1, q_fwd_data2, count
    );
endinterface

// File: rtl/rf_wsched_fifo.sv
// rf_wsched_fifo: DEPTH-entry write-request FIFO with optional forward search.
//   i_push/i_push_entry : enqueue (caller guarantees space, incl. same-cycle pop)
//   i_pop               : dequeue head (caller guarantees non-empty)
//   o_head/o_empty/o_full/o_count : head entry and occupancy
//   i_q_reg1/2 -> o_fwd_data1/2   : youngest queued data for a register index
// Macro RF_WSCHED_FORWARD_EN builds the search; otherwise forward data is 0.
module rf_wsched_fifo
    import rf_wsched_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  rf_entry_t         i_push_entry,
    input  logic              i_pop,
    output rf_entry_t         o_head,
    output logic              o_empty,
    output logic              o_full,
    output logic [CNT_W-1:0]  o_count,
    input  logic [ADDR_W-1:0] i_q_reg1,
    input  logic [ADDR_W-1:0] i_q_reg2,
    output logic [DATA_W-1:0] o_fwd_data1,
    output logic [DATA_W-1:0] o_fwd_data2
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rf_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (i_push && !i_pop)      r_count <= r_count + CNT_W'(1);
            else if (i_pop && !i_push) r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;

`ifdef RF_WSCHED_FORWARD_EN
    // reg2 beats reg1 inside one entry, matching the register file port rule.
    function automatic logic [DATA_W-1:0] fwd_pick(
        input rf_entry_t         e,
        input logic [ADDR_W-1:0] q,
        input logic [DATA_W-1:0] cur
    );
        if (e.dual && (e.reg2 == q)) return e.data2;
        if (e.reg1 == q)             return e.data1;
        return cur;
    endfunction

    // Walk head -> tail so younger matches overwrite older ones.
    always_comb begin
        logic [PTR_W-1:0] w_idx;
        o_fwd_data1 = '0;
        o_fwd_data2 = '0;
        w_idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rd_ptr + PTR_W'(k);
            if (CNT_W'(k) < r_count) begin
                o_fwd_data1 = fwd_pick(r_mem[w_idx], i_q_reg1, o_fwd_data1);
                o_fwd_data2 = fwd_pick(r_mem[w_idx], i_q_reg2, o_fwd_data2);
            end
        end
    end
`else
    logic w_unused_q;
    assign w_unused_q  = ^{i_q_reg1, i_q_reg2};
    assign o_fwd_data1 = '0;
    assign o_fwd_data2 = '0;
`endif

endmodule

// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler: round-robin write-back arbiter (A = pipeline WB,
// B = multi-cycle unit), request FIFO, register-file write driver and
// per-register pending scoreboard for decode stall decisions.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rf_write_scheduler_if.slave (requests, rf write controls,
//              scoreboard query/forward, FIFO count)
// Macro RF_WSCHED_FORWARD_EN enables forward data on q_fwd_*.
module rf_write_scheduler
    import rf_wsched_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input logic                 clk,
    input logic                 rst,
    rf_write_scheduler_if.slave bus
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PEND_W = $clog2(DEPTH * 2 + 1);
    localparam int NREG   = 1 << ADDR_W;

    logic              w_empty, w_full, w_pop, w_push, w_elig, w_gnt_a, w_gnt_b;
    rf_entry_t         w_push_entry, w_head;
    logic [CNT_W-1:0]  w_count;
    logic [DATA_W-1:0] w_fwd_data1, w_fwd_data2;
    logic [NREG-1:0]   w_pend_nz;
    req_e              r_last;

    // ---------------- drain ----------------
    assign w_pop = !w_empty && !bus.rf_hold;

    // ---------------- arbitration ----------------
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_elig = !w_full || w_pop;

    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!rst && w_elig) begin
            if (bus.a_valid && bus.b_valid) begin
                if (r_last == REQ_B) w_gnt_a = 1'b1;
                else                 w_gnt_b = 1'b1;
            end else begin
                w_gnt_a = bus.a_valid;
                w_gnt_b = bus.b_valid;
            end
        end
    end

    // Resetting to "B granted last" gives A first pick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_last <= REQ_B;
        else if (w_gnt_a) r_last <= REQ_A;
        else if (w_gnt_b) r_last <= REQ_B;
    end

    assign w_push       = w_gnt_a || w_gnt_b;
    assign w_push_entry = w_gnt_b
        ? rf_normalize(bus.b_dual, bus.b_reg1, bus.b_reg2, bus.b_data1, bus.b_data2)
        : rf_normalize(bus.a_dual, bus.a_reg1, bus.a_reg2, bus.a_data1, bus.a_data2);

    assign bus.a_ready = w_gnt_a;
    assign bus.b_ready = w_gnt_b;

    // ---------------- FIFO ----------------
    rf_wsched_fifo #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_entry(w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_count     (w_count),
        .i_q_reg1    (bus.q_reg1),
        .i_q_reg2    (bus.q_reg2),
        .o_fwd_data1 (w_fwd_data1),
        .o_fwd_data2 (w_fwd_data2)
    );

    assign bus.count     = w_count;
    assign bus.rf_we     = w_pop;
    assign bus.rf_we2    = w_pop && w_head.dual;
    assign bus.rf_wreg1  = w_empty ? '0 : w_head.reg1;
    assign bus.rf_wreg2  = w_empty ? '0 : w_head.reg2;
    assign bus.rf_wdata1 = w_empty ? '0 : w_head.data1;
    assign bus.rf_wdata2 = w_empty ? '0 : w_head.data2;

    // ---------------- scoreboard ----------------
    // Normalised dual entries never name one index twice, so each counter
    // moves by at most one per push and one per pop.
    for (genvar g = 0; g < NREG; g++) begin : g_pend
        logic [PEND_W-1:0] r_cnt;
        logic              w_inc, w_dec;

        assign w_inc = w_push && ((w_push_entry.reg1 == ADDR_W'(g)) ||
                                  (w_push_entry.dual && (w_push_entry.reg2 == ADDR_W'(g))));
        assign w_dec = w_pop  && ((w_head.reg1 == ADDR_W'(g)) ||
                                  (w_head.dual && (w_head.reg2 == ADDR_W'(g))));

        always_ff @(posedge clk or posedge rst) begin
            if (rst)                 r_cnt <= '0;
            else if (w_inc && !w_dec) r_cnt <= r_cnt + PEND_W'(1);
            else if (w_dec && !w_inc) r_cnt <= r_cnt - PEND_W'(1);
        end

        assign w_pend_nz[g] = (r_cnt != '0);
    end

    assign bus.q_busy1 = w_pend_nz[bus.q_reg1];
    assign bus.q_busy2 = w_pend_nz[bus.q_reg2];

`ifdef RF_WSCHED_FORWARD_EN
    assign bus.q_fwd_valid1 = bus.q_busy1;
    assign bus.q_fwd_valid2 = bus.q_busy2;
    assign bus.q_fwd_data1  = w_fwd_data1;
    assign bus.q_fwd_data2  = w_fwd_data2;
`else
    logic w_unused_fwd;
    assign w_unused_fwd     = ^{w_fwd_data1, w_fwd_data2};
    assign bus.q_fwd_valid1 = 1'b0;
    assign bus.q_fwd_valid2 = 1'b0;
    assign bus.q_fwd_data1  = DATA_W'(0);
    assign bus.q_fwd_data2  = DATA_W'(0);
`endif

endmodule
